des_cbc_sched: RTL and testbench

//  Shares one pipelined DES encryption core (no reset, 18-cycle id->od latency, 1 block/cycle) among NCH

---
 rtl/des_cbc_sched_if.sv | 34 +++
 rtl/des_cbc_sched.sv | 158 +++++++++++++++
 tb/tb_des_cbc_sched.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/des_cbc_sched_if.sv
// Channel-side request/response bundle and DES core port bundle for des_cbc_sched.
interface des_cbc_sched_if #(
  parameter int NCH = 4
);
  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

  logic [NCH-1:0]    in_valid;
  logic [NCH-1:0]    in_ready;
  logic [NCH-1:0]    in_first;
  logic [64*NCH-1:0] in_data;
  logic [64*NCH-1:0] in_key;
  logic [64*NCH-1:0] in_iv;

  logic [63:0]       des_id;
  logic [63:0]       des_key;
  logic              des_invalid;
  logic [63:0]       des_od;
  logic              des_outvalid;

  logic              out_valid;
  logic [63:0]       out_data;
  logic [CW-1:0]     out_ch;
  logic              err;

  modport slave (
    input  in_valid, in_first, in_data, in_key, in_iv, des_od, des_outvalid,
    output in_ready, des_id, des_key, des_invalid, out_valid, out_data, out_ch, err
  );

  modport master (
    output in_valid, in_first, in_data, in_key, in_iv, des_od, des_outvalid,
    input  in_ready, des_id, des_key, des_invalid, out_valid, out_data, out_ch, err
  );
endinterface

// File: rtl/des_cbc_sched.sv
// Round-robin scheduler sharing one pipelined DES core among NCH CBC channels,
// with per-channel chaining state and an in-order channel tag FIFO.
module des_cbc_sched #(
  parameter int NCH     = 4,
  parameter int CORELAT = 18
) (
  input  logic           clk,
  input  logic           rst,
  des_cbc_sched_if.slave bus
);
  localparam int CW     = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int DATA_W = 64;
  localparam int DCW    = $clog2(CORELAT + 2);
  localparam int QCW    = $clog2(NCH + 1);

  function automatic logic [CW-1:0] wrap_add(input logic [CW-1:0] a, input int b);
    int s;
    s = int'(a) + b;
    if (s >= NCH) s = s - NCH;
    return CW'(s);
  endfunction

  function automatic logic [DATA_W-1:0] cbc_whiten(input logic [DATA_W-1:0] pt,
                                                   input logic [DATA_W-1:0] iv,
                                                   input logic [DATA_W-1:0] chain,
                                                   input logic              first);
    return pt ^ (first ? iv : chain);
  endfunction

  logic [NCH-1:0]    r_busy;
  logic [CW-1:0]     r_rr;
  logic [DCW-1:0]    r_drain;
  logic [CW-1:0]     r_tag [NCH];
  logic [CW-1:0]     r_wr;
  logic [CW-1:0]     r_rd;
  logic [QCW-1:0]    r_cnt;
  logic              r_err;
  logic [DATA_W-1:0] r_chain [NCH];

  logic              vld_p0;
  logic [DATA_W-1:0] r_des_id_p0;
  logic [DATA_W-1:0] r_des_key_p0;

  logic              vld_p1;
  logic [DATA_W-1:0] r_out_data_p1;
  logic [CW-1:0]     r_out_ch_p1;

  logic              w_draining;
  logic [NCH-1:0]    w_elig;
  logic              w_gnt;
  logic [CW-1:0]     w_gch;
  logic [DATA_W-1:0] w_pt;
  logic [DATA_W-1:0] w_key;
  logic [DATA_W-1:0] w_iv;
  logic [DATA_W-1:0] w_chain;
  logic              w_first;
  logic              w_ret;
  logic              w_pop;
  logic              w_orphan;
  logic [CW-1:0]     w_rch;

  // The core has no reset: hold off issue until anything it still carries has flushed out.
  assign w_draining = (r_drain != '0);
  assign w_elig     = bus.in_valid & ~r_busy & {NCH{~w_draining & ~rst}};

  // Scan downward so the eligible channel closest to the pointer wins.
  always_comb begin
    w_gnt = 1'b0;
    w_gch = r_rr;
    for (int k = NCH - 1; k >= 0; k--) begin
      if (w_elig[wrap_add(r_rr, k)]) begin
        w_gnt = 1'b1;
        w_gch = wrap_add(r_rr, k);
      end
    end
  end

  assign bus.in_ready = w_gnt ? (NCH'(1) << w_gch) : '0;

  always_comb begin
    w_pt    = '0;
    w_key   = '0;
    w_iv    = '0;
    w_chain = '0;
    w_first = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (w_gch == CW'(i)) begin
        w_pt    = bus.in_data[DATA_W*i +: DATA_W];
        w_key   = bus.in_key[DATA_W*i +: DATA_W];
        w_iv    = bus.in_iv[DATA_W*i +: DATA_W];
        w_chain = r_chain[i];
        w_first = bus.in_first[i];
      end
    end
  end

  assign w_ret    = bus.des_outvalid & ~w_draining;
  assign w_pop    = w_ret & (r_cnt != '0);
  assign w_orphan = w_ret & (r_cnt == '0);
  assign w_rch    = r_tag[r_rd];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy  <= '0;
      r_rr    <= '0;
      r_drain <= DCW'(CORELAT + 1);
      r_wr    <= '0;
      r_rd    <= '0;
      r_cnt   <= '0;
      r_err   <= 1'b0;
      vld_p0  <= 1'b0;
      vld_p1  <= 1'b0;
    end else begin
      if (w_draining) r_drain <= r_drain - 1'b1;
      vld_p0 <= w_gnt;
      vld_p1 <= w_pop;
      if (w_orphan) r_err <= 1'b1;
      if (w_gnt) begin
        r_rr <= wrap_add(w_gch, 1);
        r_wr <= wrap_add(r_wr, 1);
      end
      if (w_pop) r_rd <= wrap_add(r_rd, 1);
      if (w_gnt && !w_pop)      r_cnt <= r_cnt + 1'b1;
      else if (!w_gnt && w_pop) r_cnt <= r_cnt - 1'b1;
      // A returning channel is never the one being granted: it is still busy this cycle.
      for (int i = 0; i < NCH; i++) begin
        if (w_pop && (w_rch == CW'(i))) r_busy[i] <= 1'b0;
        if (w_gnt && (w_gch == CW'(i))) r_busy[i] <= 1'b1;
      end
    end
  end

  // p0: whitened block and key presented to the core
  always_ff @(posedge clk) begin
    if (w_gnt) begin
      r_des_id_p0  <= cbc_whiten(w_pt, w_iv, w_chain, w_first);
      r_des_key_p0 <= w_key;
      r_tag[r_wr]  <= w_gch;
    end
  end

  // p1: ciphertext returned by the core, tagged with its channel
  always_ff @(posedge clk) begin
    if (w_pop) begin
      r_chain[w_rch] <= bus.des_od;
      r_out_data_p1  <= bus.des_od;
      r_out_ch_p1    <= w_rch;
    end
  end

  assign bus.des_id      = r_des_id_p0;
  assign bus.des_key     = r_des_key_p0;
  assign bus.des_invalid = vld_p0;
  assign bus.out_valid   = vld_p1;
  assign bus.out_data    = r_out_data_p1;
  assign bus.out_ch      = r_out_ch_p1;
  assign bus.err         = r_err;
endmodule

// File: tb/tb_des_cbc_sched.sv
// Bench for des_cbc_sched: a stub pipelined core, a per-cycle scoreboard model and directed tests.
module tb_des_cbc_sched;
  localparam int NCH     = 4;
  localparam int CORELAT = 18;
  localparam logic [63:0] K0 = 64'h133457799BBCDFF1;
  localparam logic [63:0] P0 = 64'h0123456789ABCDEF;
  localparam logic [63:0] C0 = 64'h85E813540F0AB405;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic force_ov = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;

  des_cbc_sched_if #(.NCH(NCH)) bus();
  des_cbc_sched #(.NCH(NCH), .CORELAT(CORELAT)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  // Stub core: known-answer DES vector, otherwise a cheap keyed mix.
  function automatic logic [63:0] core_f(input logic [63:0] k, input logic [63:0] x);
    if (k == K0 && x == P0) return C0;
    return ({x[40:0], x[63:41]} ^ k) + 64'h9E3779B97F4A7C15;
  endfunction

  logic [63:0]        core_d [CORELAT];
  logic [CORELAT-1:0] core_v = '0;
  always @(posedge clk) begin
    core_v    <= {core_v[CORELAT-2:0], bus.des_invalid};
    core_d[0] <= core_f(bus.des_key, bus.des_id);
    for (int k = 1; k < CORELAT; k++) core_d[k] <= core_d[k-1];
  end
  assign bus.des_outvalid = core_v[CORELAT-1] | force_ov;
  assign bus.des_od       = core_d[CORELAT-1];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, req);
    end
  endtask

  typedef struct { logic first; logic [63:0] data; logic [63:0] key; logic [63:0] iv; } blk_t;
  typedef struct { int ch; logic [63:0] ct; int due; } exp_t;
  typedef struct { int cyc; int ch; logic [63:0] data; } log_t;

  blk_t           src [NCH][$];
  exp_t           mq[$];
  log_t           glog[$];
  log_t           olog[$];
  logic [63:0]    m_chain [NCH];
  logic [NCH-1:0] m_busy = '0;
  int             m_rr = 0;
  int             m_drain = CORELAT + 1;
  int             m_cyc = 0;
  logic           m_err = 1'b0;

  // Source driver: present each channel's queue head shortly after every edge.
  initial begin
    bus.in_valid = '0;
    bus.in_first = '0;
    bus.in_data  = '0;
    bus.in_key   = '0;
    bus.in_iv    = '0;
    forever begin
      @(posedge clk);
      #2;
      for (int i = 0; i < NCH; i++) begin
        if (src[i].size() > 0) begin
          bus.in_valid[i]          = 1'b1;
          bus.in_first[i]          = src[i][0].first;
          bus.in_data[64*i +: 64]  = src[i][0].data;
          bus.in_key[64*i +: 64]   = src[i][0].key;
          bus.in_iv[64*i +: 64]    = src[i][0].iv;
        end else begin
          bus.in_valid[i] = 1'b0;
        end
      end
    end
  end

  // Scoreboard: decide what this cycle must look like, compare, then advance to the next edge.
  always @(negedge clk) begin : model
    logic [NCH-1:0] erdy;
    logic           eov;
    logic [63:0]    ed;
    logic [63:0]    x;
    int             ec;
    int             gsel;
    int             idx;
    exp_t           e;
    eov = 1'b0; ed = '0; ec = 0; erdy = '0; gsel = -1; x = '0;
    if (mq.size() > 0 && mq[0].due == m_cyc) begin
      eov = 1'b1; ed = mq[0].ct; ec = mq[0].ch;
      m_busy[ec] = 1'b0;
      void'(mq.pop_front());
    end
    if (!rst && m_drain == 0) begin
      for (int k = 0; k < NCH; k++) begin
        idx = (m_rr + k) % NCH;
        if (gsel < 0 && bus.in_valid[idx] && !m_busy[idx]) gsel = idx;
      end
    end
    if (gsel >= 0) erdy[gsel] = 1'b1;
    chk("in_ready", 64'(bus.in_ready), 64'(erdy));
    chk("out_valid", 64'(bus.out_valid), 64'(eov));
    if (eov) begin
      chk("out_data", bus.out_data, ed);
      chk("out_ch", 64'(bus.out_ch), 64'(ec));
    end
    chk("err", 64'(bus.err), 64'(m_err));

    if (rst) begin
      mq.delete();
      m_busy  = '0;
      m_rr    = 0;
      m_drain = CORELAT + 1;
      m_err   = 1'b0;
    end else begin
      if (force_ov && m_drain == 0 && mq.size() == 0) m_err = 1'b1;
      if (m_drain > 0) m_drain--;
      if (gsel >= 0) begin
        x = bus.in_data[64*gsel +: 64] ^
            (bus.in_first[gsel] ? bus.in_iv[64*gsel +: 64] : m_chain[gsel]);
        e.ch  = gsel;
        e.ct  = core_f(bus.in_key[64*gsel +: 64], x);
        e.due = m_cyc + CORELAT + 2;
        m_chain[gsel] = e.ct;
        mq.push_back(e);
        m_busy[gsel] = 1'b1;
        m_rr = (gsel + 1) % NCH;
      end
    end

    for (int i = 0; i < NCH; i++) begin
      if (bus.in_valid[i] && bus.in_ready[i]) begin
        glog.push_back('{m_cyc, i, 64'h0});
        if (src[i].size() > 0) void'(src[i].pop_front());
      end
    end
    if (bus.out_valid) olog.push_back('{m_cyc, int'(bus.out_ch), bus.out_data});
    m_cyc++;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input int ch, input logic first, input logic [63:0] d,
                      input logic [63:0] k, input logic [63:0] iv);
    blk_t b;
    b.first = first; b.data = d; b.key = k; b.iv = iv;
    src[ch].push_back(b);
  endtask

  function automatic bit src_pending();
    for (int i = 0; i < NCH; i++) if (src[i].size() > 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic wait_quiet(input string nm, input int maxc);
    int c;
    c = 0;
    while ((src_pending() || mq.size() > 0) && c < maxc) begin
      tick(1);
      c++;
    end
    n_chk++;
    if (c >= maxc) begin
      n_fail++;
      $display("FAIL %s: still busy after %0d cycles, expected idle", nm, c);
    end
    tick(1);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin : stim
    int r;
    int c;
    tick(3);
    chk("rst_in_ready", 64'(bus.in_ready), 64'h0);
    chk("rst_out_valid", 64'(bus.out_valid), 64'h0);
    chk("rst_des_invalid", 64'(bus.des_invalid), 64'h0);
    chk("rst_err", 64'(bus.err), 64'h0);
    r = m_cyc - 1;
    rst = 1'b0;

    // Round robin across all channels, three blocks each.
    glog.delete(); olog.delete();
    for (int i = 0; i < NCH; i++)
      for (int j = 0; j < 3; j++)
        push(i, j == 0, {32'(i), 32'(j)} ^ 64'hA5A5_5A5A_3C3C_C3C3,
             64'h0F1E2D3C4B5A6978 + 64'(i), 64'h1111_1111_1111_1111 * 64'(i + 1));
    wait_quiet("rr_quiet", 400);
    chk("drain_first_grant", 64'(glog[0].cyc - r), 64'd20);
    chk("rr_grants", 64'(glog.size()), 64'd12);
    chk("rr_outputs", 64'(olog.size()), 64'd12);
    for (int j = 0; j < 12; j++) begin
      chk("rr_grant_ch", 64'(glog[j].ch), 64'(j % 4));
      chk("rr_out_ch", 64'(olog[j].ch), 64'(j % 4));
    end
    chk("rr_back_to_back", 64'(glog[1].cyc - glog[0].cyc), 64'd1);
    chk("rr_regrant_at_output", 64'(glog[4].cyc - glog[0].cyc), 64'd20);

    // Single-block known answer.
    glog.delete(); olog.delete();
    push(0, 1'b1, P0, K0, 64'h0);
    wait_quiet("single_quiet", 60);
    chk("single_data", olog[0].data, C0);
    chk("single_ch", 64'(olog[0].ch), 64'd0);
    chk("single_latency", 64'(olog[0].cyc - glog[0].cyc), 64'd20);

    // Second block chains on the previous ciphertext; IV must be ignored.
    glog.delete(); olog.delete();
    push(0, 1'b0, P0 ^ C0, K0, 64'hFFFF_FFFF_FFFF_FFFF);
    wait_quiet("chain_quiet", 60);
    chk("chain_data", olog[0].data, C0);

    // Move the pointer to 2, then offer ch1 and ch3 together.
    push(1, 1'b1, 64'h1, 64'h2, 64'h3);
    wait_quiet("wrap_setup_quiet", 60);
    glog.delete(); olog.delete();
    push(1, 1'b0, 64'h4444, 64'h5555, 64'h0);
    push(3, 1'b1, 64'h6666, 64'h7777, 64'h8888);
    wait_quiet("wrap_quiet", 80);
    chk("wrap_first", 64'(glog[0].ch), 64'd3);
    chk("wrap_second", 64'(glog[1].ch), 64'd1);

    // Reset with three blocks in flight.
    glog.delete();
    push(0, 1'b1, 64'hAAAA, 64'hBBBB, 64'hCCCC);
    push(1, 1'b1, 64'hDDDD, 64'hEEEE, 64'hFFFF);
    push(2, 1'b1, 64'h1234, 64'h5678, 64'h9ABC);
    c = 0;
    while (glog.size() < 3 && c < 50) begin tick(1); c++; end
    chk("midflight_issued", 64'(glog.size()), 64'd3);
    tick(2);
    olog.delete();
    rst = 1'b1;
    r = m_cyc;
    tick(1);
    rst = 1'b0;
    tick(5);
    force_ov = 1'b1;
    tick(1);
    force_ov = 1'b0;
    glog.delete();
    push(2, 1'b1, 64'h0BAD_F00D_0000_0001, 64'h0123_4567_0000_0002, 64'h0000_0000_DEAD_BEEF);
    push(0, 1'b1, 64'h0BAD_F00D_0000_0003, 64'h0123_4567_0000_0004, 64'h0000_0000_CAFE_F00D);
    wait_quiet("post_reset_quiet", 120);
    chk("post_reset_first_grant", 64'(glog[0].cyc - r), 64'd20);
    chk("post_reset_order0", 64'(glog[0].ch), 64'd0);
    chk("post_reset_order1", 64'(glog[1].ch), 64'd2);
    chk("post_reset_outputs", 64'(olog.size()), 64'd2);
    chk("post_reset_err", 64'(bus.err), 64'h0);

    // Orphan core output with nothing outstanding.
    tick(2);
    force_ov = 1'b1;
    tick(1);
    force_ov = 1'b0;
    tick(2);
    chk("orphan_err", 64'(bus.err), 64'h1);
    chk("orphan_no_output", 64'(bus.out_valid), 64'h0);
    tick(4);
    chk("orphan_err_sticky", 64'(bus.err), 64'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
